// File: rtl/nanov_periph.sv
// Memory-mapped peripheral block for a tiny CPU: GPIO output/input registers,
// plus UART TX/RX byte FIFOs with status and sticky overflow flags.
module nanov_periph #(
    parameter int unsigned GPIO_OUT_W = 32,
    parameter int unsigned GPIO_IN_W  = 3,
    parameter int unsigned TX_DEPTH   = 4,
    parameter int unsigned RX_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  is_addr,
    input  logic                  is_data,
    input  logic [31:0]           data_out,
    output logic [31:0]           data_in,
    output logic [GPIO_OUT_W-1:0] gpio_out,
    input  logic [GPIO_IN_W-1:0]  gpio_in,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data
);

    localparam int unsigned TXA = $clog2(TX_DEPTH);
    localparam int unsigned RXA = $clog2(RX_DEPTH);
    localparam logic [TXA:0] TX_ONE = 1;
    localparam logic [RXA:0] RX_ONE = 1;

    localparam logic [31:0] ADDR_GPIO   = BASE_ADDR;
    localparam logic [31:0] ADDR_TX     = BASE_ADDR + 32'h0000_1000;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h0000_1004;
    localparam logic [31:0] ADDR_RX     = BASE_ADDR + 32'h0000_1008;

    logic sel_gpio, sel_tx, sel_status, sel_rx;
    logic [31:0] wdata;
    logic [GPIO_IN_W-1:0] gpio_meta, gpio_sync;

    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];
    logic [TXA:0] tx_wptr, tx_rptr;
    logic [RXA:0] rx_wptr, rx_rptr;
    logic tx_ovf, rx_ovf;

    logic tx_empty, tx_full, tx_wr, tx_push, tx_pop;
    logic rx_empty, rx_full, rx_pop, rx_push;
    logic st_wr;
    logic [31:0] status;

    // The CPU delivers write data MSB-first on the bus
    always_comb begin
        wdata = '0;
        for (int i = 0; i < 32; i++) begin
            wdata[i] = data_out[31-i];
        end
    end

    always_comb begin
        tx_empty = (tx_wptr == tx_rptr);
        tx_full  = (tx_wptr[TXA] != tx_rptr[TXA]) &&
                   (tx_wptr[TXA-1:0] == tx_rptr[TXA-1:0]);
        rx_empty = (rx_wptr == rx_rptr);
        rx_full  = (rx_wptr[RXA] != rx_rptr[RXA]) &&
                   (rx_wptr[RXA-1:0] == rx_rptr[RXA-1:0]);
        tx_wr    = is_data && sel_tx;
        tx_push  = tx_wr && !tx_full;
        tx_pop   = !tx_empty && !tx_busy && !tx_start;
        rx_pop   = is_data && sel_rx && !rx_empty;
        rx_push  = rx_valid && (!rx_full || rx_pop);
        st_wr    = is_data && sel_status;
        status   = {26'd0, tx_busy, rx_ovf, tx_ovf, !rx_empty, tx_empty, tx_full};
    end

    // Read mux follows the selection latched by the last address strobe
    always_comb begin
        data_in = '0;
        if (sel_gpio) begin
            data_in = 32'(gpio_sync);
        end else if (sel_status) begin
            data_in = status;
        end else if (sel_rx && !rx_empty) begin
            data_in = 32'(rx_mem[rx_rptr[RXA-1:0]]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_gpio   <= 1'b0;
            sel_tx     <= 1'b0;
            sel_status <= 1'b0;
            sel_rx     <= 1'b0;
            gpio_out   <= '0;
            gpio_meta  <= '0;
            gpio_sync  <= '0;
            tx_wptr    <= '0;
            tx_rptr    <= '0;
            rx_wptr    <= '0;
            rx_rptr    <= '0;
            tx_ovf     <= 1'b0;
            rx_ovf     <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
        end else begin
            if (is_addr) begin
                sel_gpio   <= (data_out == ADDR_GPIO);
                sel_tx     <= (data_out == ADDR_TX);
                sel_status <= (data_out == ADDR_STATUS);
                sel_rx     <= (data_out == ADDR_RX);
            end
            if (is_data && sel_gpio) begin
                gpio_out <= wdata[GPIO_OUT_W-1:0];
            end
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;

            // Start is registered; its own previous value paces back-to-back bytes
            tx_start <= tx_pop;
            if (tx_pop) begin
                tx_data <= tx_mem[tx_rptr[TXA-1:0]];
                tx_rptr <= tx_rptr + TX_ONE;
            end
            if (tx_push) begin
                tx_wptr <= tx_wptr + TX_ONE;
            end
            if (rx_pop) begin
                rx_rptr <= rx_rptr + RX_ONE;
            end
            if (rx_push) begin
                rx_wptr <= rx_wptr + RX_ONE;
            end

            // Overflow set events take priority over software clears
            if (tx_wr && tx_full) begin
                tx_ovf <= 1'b1;
            end else if (st_wr && wdata[3]) begin
                tx_ovf <= 1'b0;
            end
            if (rx_valid && !rx_push) begin
                rx_ovf <= 1'b1;
            end else if (st_wr && wdata[4]) begin
                rx_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr[TXA-1:0]] <= wdata[7:0];
        end
        if (rx_push) begin
            rx_mem[rx_wptr[RXA-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_nanov_periph.sv
// Self-checking bench for nanov_periph: directed scenarios plus a randomized
// run compared against a queue-based behavioural model of the register map.
module tb_nanov_periph;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] A_GPIO = BASE;
    localparam logic [31:0] A_TX = BASE + 32'h1000;
    localparam logic [31:0] A_ST = BASE + 32'h1004;
    localparam logic [31:0] A_RX = BASE + 32'h1008;
    localparam int TXD = 4;
    localparam int RXD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        is_addr = 1'b0;
    logic        is_data = 1'b0;
    logic [31:0] data_out = '0;
    logic [31:0] data_in;
    logic [31:0] gpio_out;
    logic [2:0]  gpio_in = '0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;

    int n_checks = 0;
    int n_pass = 0;

    nanov_periph dut (
        .clk(clk), .rst(rst), .is_addr(is_addr), .is_data(is_data),
        .data_out(data_out), .data_in(data_in), .gpio_out(gpio_out),
        .gpio_in(gpio_in), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    // Reference model: 0 none, 1 gpio, 2 txdata, 3 status, 4 rxdata
    int          m_sel;
    logic [31:0] m_gpio;
    logic [7:0]  m_txq[$];
    logic [7:0]  m_rxq[$];
    logic        m_tx_ovf, m_rx_ovf, m_start;
    logic [7:0]  m_tdata;
    logic [2:0]  m_g1, m_g2;

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    function automatic int decode(input logic [31:0] a);
        if (a == A_GPIO) return 1;
        if (a == A_TX) return 2;
        if (a == A_ST) return 3;
        if (a == A_RX) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] exp_din();
        logic [31:0] st;
        st = 0;
        st[0] = (m_txq.size() == TXD);
        st[1] = (m_txq.size() == 0);
        st[2] = (m_rxq.size() != 0);
        st[3] = m_tx_ovf;
        st[4] = m_rx_ovf;
        st[5] = tx_busy;
        case (m_sel)
            1: return {29'd0, m_g2};
            3: return st;
            4: return (m_rxq.size() != 0) ? {24'd0, m_rxq[0]} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] wd;
        bit pop_t, push_t, set_t, pop_r, push_r, set_r;
        if (rst) begin
            m_sel = 0; m_gpio = 0; m_txq.delete(); m_rxq.delete();
            m_tx_ovf = 0; m_rx_ovf = 0; m_start = 0; m_tdata = 0;
            m_g1 = 0; m_g2 = 0;
            return;
        end
        wd = bitrev(data_out);
        pop_t  = (m_txq.size() != 0) && !tx_busy && !m_start;
        push_t = is_data && m_sel == 2 && m_txq.size() < TXD;
        set_t  = is_data && m_sel == 2 && m_txq.size() >= TXD;
        pop_r  = is_data && m_sel == 4 && m_rxq.size() != 0;
        push_r = rx_valid && (m_rxq.size() < RXD || pop_r);
        set_r  = rx_valid && !push_r;
        m_start = pop_t;
        if (pop_t) m_tdata = m_txq.pop_front();
        if (push_t) m_txq.push_back(wd[7:0]);
        if (pop_r) void'(m_rxq.pop_front());
        if (push_r) m_rxq.push_back(rx_data);
        if (is_data && m_sel == 3) begin
            if (wd[3]) m_tx_ovf = 0;
            if (wd[4]) m_rx_ovf = 0;
        end
        if (set_t) m_tx_ovf = 1;
        if (set_r) m_rx_ovf = 1;
        if (is_data && m_sel == 1) m_gpio = wd;
        if (is_addr) m_sel = decode(data_out);
        m_g2 = m_g1;
        m_g1 = gpio_in;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic sel_reg(input logic [31:0] a);
        is_addr = 1; is_data = 0; data_out = a;
        tick();
        is_addr = 0;
    endtask

    task automatic wr(input logic [31:0] w);
        is_data = 1; data_out = bitrev(w);
        tick();
        is_data = 0; data_out = 0;
    endtask

    task automatic do_reset();
        rst = 1; is_addr = 0; is_data = 0; data_out = 0; rx_valid = 0;
        tx_busy = 0; gpio_in = 0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (gpio_out !== 32'd0) $display("FAIL reset_gpio_out got %h want 0", gpio_out); else n_pass++;
        n_checks++; if (data_in !== 32'd0) $display("FAIL reset_data_in got %h want 0", data_in); else n_pass++;
        n_checks++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start got %b want 0", tx_start); else n_pass++;
        n_checks++; if (tx_data !== 8'd0) $display("FAIL reset_tx_data got %h want 0", tx_data); else n_pass++;
    endtask

    task automatic test_gpio();
        do_reset();
        sel_reg(A_GPIO);
        is_data = 1; data_out = 32'h0000_000F;
        tick();
        is_data = 0;
        n_checks++; if (gpio_out !== 32'hF000_0000) $display("FAIL gpio_write got %h want f0000000", gpio_out); else n_pass++;
        gpio_in = 3'b101;
        tick();
        n_checks++; if (data_in !== 32'd0) $display("FAIL gpio_sync_latency got %h want 0", data_in); else n_pass++;
        tick();
        n_checks++; if (data_in !== 32'h5) $display("FAIL gpio_read got %h want 5", data_in); else n_pass++;
    endtask

    task automatic test_tx_burst();
        logic [7:0] got[$];
        bit prev;
        int consec;
        do_reset();
        tx_busy = 1;
        sel_reg(A_TX);
        for (int i = 0; i < 5; i++) wr(32'(8'hA1 + i));
        sel_reg(A_ST);
        n_checks++; if (data_in !== 32'h29) $display("FAIL tx_burst_status got %h want 29", data_in); else n_pass++;
        tx_busy = 0;
        prev = 0; consec = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_start) begin
                got.push_back(tx_data);
                if (prev) consec++;
            end
            prev = tx_start;
        end
        n_checks++; if (got.size() != 4) $display("FAIL tx_burst_count got %0d want 4", got.size()); else n_pass++;
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== 8'(8'hA1 + i)) $display("FAIL tx_burst_byte%0d got %h want %h", i, got[i], 8'(8'hA1 + i));
            else n_pass++;
        end
        n_checks++; if (consec != 0) $display("FAIL tx_burst_consecutive got %0d want 0", consec); else n_pass++;
    endtask

    task automatic test_tx_pacing();
        logic [7:0] got[$];
        bit prev;
        int consec, busy_starts;
        do_reset();
        sel_reg(A_TX);
        prev = 0; consec = 0; busy_starts = 0;
        for (int i = 0; i < 12; i++) begin
            tx_busy = (i >= 3 && i < 6);
            is_data = (i < 2);
            data_out = bitrev((i == 0) ? 32'h3C : 32'hC3);
            tick();
            if (tx_start) begin
                got.push_back(tx_data);
                if (prev) consec++;
                if (tx_busy) busy_starts++;
            end
            prev = tx_start;
        end
        is_data = 0; tx_busy = 0;
        n_checks++; if (got.size() != 2) $display("FAIL tx_pacing_count got %0d want 2", got.size()); else n_pass++;
        n_checks++; if (consec != 0) $display("FAIL tx_pacing_consecutive got %0d want 0", consec); else n_pass++;
        n_checks++; if (busy_starts != 0) $display("FAIL tx_pacing_busy_start got %0d want 0", busy_starts); else n_pass++;
        if (got.size() == 2) begin
            n_checks++; if (got[0] !== 8'h3C) $display("FAIL tx_pacing_byte0 got %h want 3c", got[0]); else n_pass++;
            n_checks++; if (got[1] !== 8'hC3) $display("FAIL tx_pacing_byte1 got %h want c3", got[1]); else n_pass++;
        end
    endtask

    task automatic test_rx();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1; rx_data = 8'(8'h41 + i);
            tick();
        end
        rx_valid = 0;
        sel_reg(A_ST);
        n_checks++; if (data_in !== 32'h16) $display("FAIL rx_status_full got %h want 16", data_in); else n_pass++;
        sel_reg(A_RX);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (data_in !== 32'(8'h41 + i)) $display("FAIL rx_read%0d got %h want %h", i, data_in, 32'(8'h41 + i));
            else n_pass++;
            is_data = 1; tick(); is_data = 0;
        end
        sel_reg(A_ST);
        wr(32'h10);
        n_checks++; if (data_in !== 32'h02) $display("FAIL rx_ovf_clear got %h want 02", data_in); else n_pass++;
        sel_reg(A_RX);
        n_checks++; if (data_in !== 32'h0) $display("FAIL rx_read_empty got %h want 0", data_in); else n_pass++;
    endtask

    task automatic test_corner();
        logic [7:0] exp_b[4] = '{8'h62, 8'h63, 8'h64, 8'h55};
        do_reset();
        sel_reg(A_RX);
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1; rx_data = 8'(8'h61 + i);
            tick();
        end
        rx_valid = 1; rx_data = 8'h55; is_data = 1;
        tick();
        rx_valid = 0; is_data = 0;
        sel_reg(A_ST);
        n_checks++; if (data_in !== 32'h06) $display("FAIL corner_no_overflow got %h want 06", data_in); else n_pass++;
        sel_reg(A_RX);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (data_in !== 32'(exp_b[i])) $display("FAIL corner_read%0d got %h want %h", i, data_in, exp_b[i]);
            else n_pass++;
            is_data = 1; tick(); is_data = 0;
        end
        n_checks++; if (data_in !== 32'h0) $display("FAIL corner_count got %h want 0", data_in); else n_pass++;
        sel_reg(A_GPIO);
        is_addr = 1; is_data = 1; data_out = A_ST;
        tick();
        is_addr = 0; is_data = 0;
        n_checks++; if (gpio_out !== 32'h2008_0008) $display("FAIL corner_addr_data_gpio got %h want 20080008", gpio_out); else n_pass++;
        n_checks++; if (data_in !== 32'h02) $display("FAIL corner_addr_data_sel got %h want 02", data_in); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int starts;
        do_reset();
        tx_busy = 1;
        sel_reg(A_TX);
        for (int i = 0; i < 3; i++) wr(32'(8'h10 + i));
        sel_reg(A_GPIO);
        wr(32'hFF);
        rst = 1; tx_busy = 0;
        tick();
        rst = 0;
        n_checks++; if (gpio_out !== 32'd0) $display("FAIL rst_mid_gpio got %h want 0", gpio_out); else n_pass++;
        n_checks++; if (data_in !== 32'd0) $display("FAIL rst_mid_data_in got %h want 0", data_in); else n_pass++;
        starts = tx_start ? 1 : 0;
        sel_reg(A_ST);
        n_checks++; if (data_in !== 32'h02) $display("FAIL rst_mid_status got %h want 02", data_in); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (tx_start) starts++;
            tick();
        end
        n_checks++; if (starts != 0) $display("FAIL rst_mid_tx_start got %0d want 0", starts); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] addrs[4] = '{A_GPIO, A_TX, A_ST, A_RX};
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            is_addr = ($urandom_range(0, 3) == 0);
            data_out = is_addr ? (($urandom_range(0, 5) < 5) ? addrs[$urandom_range(0, 3)] : $urandom)
                               : $urandom;
            is_data = ($urandom_range(0, 1) == 1);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data = 8'($urandom);
            tx_busy = ($urandom_range(0, 1) == 1);
            gpio_in = 3'($urandom);
            tick();
            e = exp_din();
            n_checks++; if (gpio_out !== m_gpio) $display("FAIL rand_gpio_out cyc %0d got %h want %h", i, gpio_out, m_gpio); else n_pass++;
            n_checks++; if (data_in !== e) $display("FAIL rand_data_in cyc %0d got %h want %h", i, data_in, e); else n_pass++;
            n_checks++; if (tx_start !== m_start) $display("FAIL rand_tx_start cyc %0d got %b want %b", i, tx_start, m_start); else n_pass++;
            n_checks++; if (tx_data !== m_tdata) $display("FAIL rand_tx_data cyc %0d got %h want %h", i, tx_data, m_tdata); else n_pass++;
        end
        rst = 0; is_addr = 0; is_data = 0; rx_valid = 0; tx_busy = 0;
    endtask

    initial begin
        test_reset();
        test_gpio();
        test_tx_burst();
        test_tx_pacing();
        test_rx();
        test_corner();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
